// File: rtl/sram_burst_arbiter_if.sv
// rtl/sram_burst_arbiter_if.sv - requester and SRAM-side signal bundle for sram_burst_arbiter
// Purpose: groups both requester channels and the array-side strobes into one interface.
// Ports:
//   req0_* / req1_*  burst command (valid/ready/write/addr/cnt), write beats
//                    (wdata/wvalid/wready), read return (rdata/rvalid) and
//                    completion (done/err)
//   sram_*           array address, write data, write/sense strobes, read data
// Modports: slave = arbiter side, master = requesters plus array model.
interface sram_burst_arbiter_if #(
  parameter int N_addr = 12,
  parameter int N_data = 8,
  parameter int N_cnt  = 12
);
  logic              req0_valid, req0_ready, req0_write;
  logic [N_addr-1:0] req0_addr;
  logic [N_cnt-1:0]  req0_cnt;
  logic [N_data-1:0] req0_wdata, req0_rdata;
  logic              req0_wvalid, req0_wready, req0_rvalid, req0_done, req0_err;

  logic              req1_valid, req1_ready, req1_write;
  logic [N_addr-1:0] req1_addr;
  logic [N_cnt-1:0]  req1_cnt;
  logic [N_data-1:0] req1_wdata, req1_rdata;
  logic              req1_wvalid, req1_wready, req1_rvalid, req1_done, req1_err;

  logic [N_addr-1:0] sram_addr;
  logic [N_data-1:0] sram_din, sram_dout;
  logic              sram_write_en, sram_sense_en;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_cnt, req0_wdata, req0_wvalid,
    output req0_ready, req0_wready, req0_rdata, req0_rvalid, req0_done, req0_err,
    input  req1_valid, req1_write, req1_addr, req1_cnt, req1_wdata, req1_wvalid,
    output req1_ready, req1_wready, req1_rdata, req1_rvalid, req1_done, req1_err,
    output sram_addr, sram_din, sram_write_en, sram_sense_en,
    input  sram_dout
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_cnt, req0_wdata, req0_wvalid,
    input  req0_ready, req0_wready, req0_rdata, req0_rvalid, req0_done, req0_err,
    output req1_valid, req1_write, req1_addr, req1_cnt, req1_wdata, req1_wvalid,
    input  req1_ready, req1_wready, req1_rdata, req1_rvalid, req1_done, req1_err,
    input  sram_addr, sram_din, sram_write_en, sram_sense_en,
    output sram_dout
  );
endinterface

// File: rtl/sram_burst_arbiter.sv
// rtl/sram_burst_arbiter.sv - two-port round-robin burst arbiter in front of one SRAM array
// Purpose: grants one burst at a time, sequences per-beat SRAM strobes, returns
//          read data after SRAM_LAT cycles and pulses done at burst end.
// Ports:
//   clk  system clock
//   rst  synchronous reset, active-high
//   bus  sram_burst_arbiter_if.slave (req0_*, req1_*, sram_*)
// Optional: define SRAM_ARB_TIMEOUT_EN to abort write bursts whose data stalls
//           for TIMEOUT_CYC cycles (reqN_err pulses with reqN_done).
module sram_burst_arbiter #(
  parameter int N_addr      = 12,
  parameter int N_data      = 8,
  parameter int N_cnt       = 12,
  parameter int SRAM_LAT    = 1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_burst_arbiter_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t            state;
  logic              gnt, last_grant;
  logic [N_addr-1:0] base;
  logic [N_cnt-1:0]  cnt, beat;
  logic [1:0]        ready_q, wready_q, done_q;
  logic [N_addr-1:0] addr_q;
  logic [N_data-1:0] din_q;
  logic              we_q, se_q;
  // vpipe[i]: a read beat issued i+1 cycles ago is in flight; ppipe[i]: its port
  logic [SRAM_LAT-1:0] vpipe, ppipe;

`ifdef SRAM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
  logic          aborted;
  logic [1:0]    err_q;
`endif

  logic              any_req, pick, pipe_busy, wvalid_g;
  logic [N_data-1:0] wdata_g;

  always_comb begin
    any_req = bus.req0_valid | bus.req1_valid;
    // On a tie, the port that did not win last time goes first
    if (bus.req0_valid && bus.req1_valid) pick = ~last_grant;
    else                                  pick = bus.req1_valid;
    wvalid_g = gnt ? bus.req1_wvalid : bus.req0_wvalid;
    wdata_g  = gnt ? bus.req1_wdata  : bus.req0_wdata;
    // The last stage delivers this cycle, so only earlier stages keep DRAIN busy
    pipe_busy = 1'b0;
    for (int i = 0; i < SRAM_LAT - 1; i++) pipe_busy = pipe_busy | vpipe[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      base       <= '0;
      cnt        <= '0;
      beat       <= '0;
      ready_q    <= '0;
      wready_q   <= '0;
      done_q     <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      we_q       <= 1'b0;
      se_q       <= 1'b0;
      vpipe      <= '0;
      ppipe      <= '0;
`ifdef SRAM_ARB_TIMEOUT_EN
      tcnt       <= '0;
      aborted    <= 1'b0;
      err_q      <= '0;
`endif
    end else begin
      ready_q <= '0;
      done_q  <= '0;
      we_q    <= 1'b0;
      se_q    <= 1'b0;
`ifdef SRAM_ARB_TIMEOUT_EN
      err_q   <= '0;
`endif
      vpipe[0] <= se_q;
      ppipe[0] <= gnt;
      for (int i = 1; i < SRAM_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
        ppipe[i] <= ppipe[i-1];
      end

      case (state)
        IDLE: begin
          if (any_req) begin
            gnt        <= pick;
            last_grant <= pick;
            base       <= pick ? bus.req1_addr : bus.req0_addr;
            cnt        <= pick ? bus.req1_cnt  : bus.req0_cnt;
            beat       <= '0;
            ready_q    <= pick ? 2'b10 : 2'b01;
`ifdef SRAM_ARB_TIMEOUT_EN
            tcnt       <= '0;
            aborted    <= 1'b0;
`endif
            if (pick ? bus.req1_write : bus.req0_write) begin
              wready_q <= pick ? 2'b10 : 2'b01;
              state    <= WRITE;
            end else begin
              state    <= READ;
            end
          end
        end
        WRITE: begin
          // wready is held for the whole burst, so wvalid alone marks a transfer
          if (wvalid_g) begin
            we_q   <= 1'b1;
            addr_q <= base + N_addr'(beat);
            din_q  <= wdata_g;
            beat   <= beat + N_cnt'(1);
`ifdef SRAM_ARB_TIMEOUT_EN
            tcnt   <= '0;
`endif
            if (beat == cnt) begin
              wready_q <= '0;
              state    <= DONE;
            end
          end
`ifdef SRAM_ARB_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            wready_q <= '0;
            aborted  <= 1'b1;
            state    <= DONE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
`endif
        end
        READ: begin
          se_q   <= 1'b1;
          addr_q <= base + N_addr'(beat);
          beat   <= beat + N_cnt'(1);
          if (beat == cnt) state <= DRAIN;
        end
        DRAIN: begin
          if (!se_q && !pipe_busy) state <= DONE;
        end
        DONE: begin
          done_q <= gnt ? 2'b10 : 2'b01;
`ifdef SRAM_ARB_TIMEOUT_EN
          if (aborted) err_q <= gnt ? 2'b10 : 2'b01;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready    = ready_q[0];
  assign bus.req1_ready    = ready_q[1];
  assign bus.req0_wready   = wready_q[0];
  assign bus.req1_wready   = wready_q[1];
  assign bus.req0_done     = done_q[0];
  assign bus.req1_done     = done_q[1];
  assign bus.req0_rvalid   = vpipe[SRAM_LAT-1] & ~ppipe[SRAM_LAT-1];
  assign bus.req1_rvalid   = vpipe[SRAM_LAT-1] &  ppipe[SRAM_LAT-1];
  assign bus.req0_rdata    = bus.req0_rvalid ? bus.sram_dout : '0;
  assign bus.req1_rdata    = bus.req1_rvalid ? bus.sram_dout : '0;
  assign bus.sram_addr     = addr_q;
  assign bus.sram_din      = din_q;
  assign bus.sram_write_en = we_q;
  assign bus.sram_sense_en = se_q;
`ifdef SRAM_ARB_TIMEOUT_EN
  assign bus.req0_err      = err_q[0];
  assign bus.req1_err      = err_q[1];
`else
  assign bus.req0_err      = 1'b0;
  assign bus.req1_err      = 1'b0;
`endif
endmodule
